i2s_rx_capture: RTL

//   Front-end I2S slave receiver for the equalizer path. Samples the CODEC's BCLK, LRCLK and DATA
//   (asynchronous to clk) through synchronizers, deserialises standard Philips I2S frames, and

---
 rtl/i2s_rx_capture_if.sv | 22 ++
 rtl/i2s_rx_capture.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/i2s_rx_capture_if.sv
// Pin and sample bundle between an I2S CODEC and the i2s_rx_capture receiver.
interface i2s_rx_capture_if #(
  parameter int DATA_W = 24
);
  logic              i2s_bclk;
  logic              i2s_lrclk;
  logic              i2s_data;
  logic [DATA_W-1:0] audio_left;
  logic [DATA_W-1:0] audio_right;
  logic              sample_valid;
  logic              short_word;

  modport slave (
    input  i2s_bclk, i2s_lrclk, i2s_data,
    output audio_left, audio_right, sample_valid, short_word
  );

  modport master (
    output i2s_bclk, i2s_lrclk, i2s_data,
    input  audio_left, audio_right, sample_valid, short_word
  );
endinterface

// File: rtl/i2s_rx_capture.sv
// Philips I2S slave receiver: synchronises BCLK/LRCLK/DATA into clk, deserialises
// left/right words and emits one paired sample per frame; short words are discarded.
module i2s_rx_capture #(
  parameter int DATA_W      = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  i2s_rx_capture_if.slave    bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
  logic [SYNC_STAGES-1:0] lrclk_sync_q, lrclk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   bclk_prev_q, bclk_prev_d;
  logic                   lr_prev_q, lr_prev_d;
  logic                   chan_q, chan_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic [DATA_W-1:0]      left_hold_q, left_hold_d;
  logic                   left_ok_q, left_ok_d;
  logic [DATA_W-1:0]      left_q, left_d;
  logic [DATA_W-1:0]      right_q, right_d;
  logic                   valid_q, valid_d;
  logic                   short_q, short_d;

  logic bclk_s, lr_s, data_s, bit_edge, boundary;

  // lrclk and data are read from the same synchroniser stage as bclk to stay aligned.
  assign bclk_s   = bclk_sync_q[SYNC_STAGES-1];
  assign lr_s     = lrclk_sync_q[SYNC_STAGES-1];
  assign data_s   = data_sync_q[SYNC_STAGES-1];
  assign bit_edge = bclk_s & ~bclk_prev_q;
  assign boundary = lr_s != lr_prev_q;

  always_comb begin
    bclk_sync_d  = {bclk_sync_q[SYNC_STAGES-2:0], bus.i2s_bclk};
    lrclk_sync_d = {lrclk_sync_q[SYNC_STAGES-2:0], bus.i2s_lrclk};
    data_sync_d  = {data_sync_q[SYNC_STAGES-2:0], bus.i2s_data};
    bclk_prev_d  = bclk_s;
    state_d      = state_q;
    lr_prev_d    = lr_prev_q;
    chan_d       = chan_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    left_hold_d  = left_hold_q;
    left_ok_d    = left_ok_q;
    left_d       = left_q;
    right_d      = right_q;
    valid_d      = 1'b0;
    short_d      = 1'b0;

    if (bit_edge) begin
      lr_prev_d = lr_s;
      case (state_q)
        S_IDLE: begin
          // Only a fresh left boundary starts a frame; right-first streams wait here.
          if (boundary && !lr_s) begin
            state_d   = S_SHIFT;
            chan_d    = 1'b0;
            bit_cnt_d = '0;
            shift_d   = '0;
            left_ok_d = 1'b0;
          end
        end
        S_SHIFT: begin
          if (boundary) begin
            short_d   = 1'b1;
            left_ok_d = 1'b0;
            bit_cnt_d = '0;
            shift_d   = '0;
            chan_d    = 1'b0;
            state_d   = lr_s ? S_IDLE : S_SHIFT;
          end else begin
            shift_d   = {shift_q[DATA_W-2:0], data_s};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
              state_d = S_WAIT;
              if (!chan_q) begin
                left_hold_d = shift_d;
                left_ok_d   = 1'b1;
              end else if (left_ok_q) begin
                left_d    = left_hold_q;
                right_d   = shift_d;
                valid_d   = 1'b1;
                left_ok_d = 1'b0;
              end
            end
          end
        end
        S_WAIT: begin
          if (boundary) begin
            state_d   = S_SHIFT;
            chan_d    = lr_s;
            bit_cnt_d = '0;
            shift_d   = '0;
            if (!lr_s) begin
              left_ok_d = 1'b0;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bclk_sync_q  <= '0;
      lrclk_sync_q <= '0;
      data_sync_q  <= '0;
      bclk_prev_q  <= 1'b0;
      lr_prev_q    <= 1'b0;
      chan_q       <= 1'b0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      left_hold_q  <= '0;
      left_ok_q    <= 1'b0;
      left_q       <= '0;
      right_q      <= '0;
      valid_q      <= 1'b0;
      short_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      bclk_sync_q  <= bclk_sync_d;
      lrclk_sync_q <= lrclk_sync_d;
      data_sync_q  <= data_sync_d;
      bclk_prev_q  <= bclk_prev_d;
      lr_prev_q    <= lr_prev_d;
      chan_q       <= chan_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      left_hold_q  <= left_hold_d;
      left_ok_q    <= left_ok_d;
      left_q       <= left_d;
      right_q      <= right_d;
      valid_q      <= valid_d;
      short_q      <= short_d;
    end
  end

  assign bus.audio_left   = left_q;
  assign bus.audio_right  = right_q;
  assign bus.sample_valid = valid_q;
  assign bus.short_word   = short_q;
endmodule
